alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU: round-robin grant, one op in flight.
// Optional build macro ALU_ARB_OPCHECK_EN rejects opcodes outside {0000,0001,0010,0110} with resp_err.
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*DATA_WIDTH-1:0] req_a,
  input  logic [2*DATA_WIDTH-1:0] req_b,
  input  logic [7:0]              req_op,
  output logic [1:0]              resp_valid,
  input  logic [1:0]              resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_result,
  output logic                    resp_zero,
  output logic                    resp_err,
  output logic                    busy,
  output logic [DATA_WIDTH-1:0]   alu_data_rs1,
  output logic [DATA_WIDTH-1:0]   alu_source_2,
  output logic [3:0]              alu_inst,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic                    alu_zero
);

  localparam int unsigned OP_W = 4;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state;
  logic                  prio;
  logic                  owner;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [OP_W-1:0]       op_q;
  logic                  bad_q;

  logic [1:0]            grant;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [OP_W-1:0]       sel_op;
  logic                  op_legal;

  // Grant is only offered while idle and out of reset; ties go to the priority pointer.
  always_comb begin
    grant = 2'b00;
    if (state == ST_IDLE && !rst) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;

  always_comb begin
    sel_a  = grant[1] ? req_a[2*DATA_WIDTH-1:DATA_WIDTH] : req_a[DATA_WIDTH-1:0];
    sel_b  = grant[1] ? req_b[2*DATA_WIDTH-1:DATA_WIDTH] : req_b[DATA_WIDTH-1:0];
    sel_op = grant[1] ? req_op[7:4] : req_op[3:0];
  end

`ifdef ALU_ARB_OPCHECK_EN
  always_comb begin
    op_legal = (sel_op == 4'b0010) || (sel_op == 4'b0110) ||
               (sel_op == 4'b0000) || (sel_op == 4'b0001);
  end
`else
  assign op_legal = 1'b1;
`endif

  assign alu_data_rs1 = a_q;
  assign alu_source_2 = b_q;
  assign alu_inst     = op_q;

  // Sequencer: IDLE -> EXEC (ALU settles on latched operands) -> RESP (held until handshake).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      prio        <= 1'b0;
      owner       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      bad_q       <= 1'b0;
      resp_valid  <= 2'b00;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            owner <= grant[1];
            a_q   <= sel_a;
            b_q   <= sel_b;
            op_q  <= op_legal ? sel_op : OP_ADD;
            bad_q <= ~op_legal;
            busy  <= 1'b1;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_result <= bad_q ? '0 : alu_result;
          resp_zero   <= bad_q ? 1'b0 : alu_zero;
          resp_err    <= bad_q;
          resp_valid  <= owner ? 2'b10 : 2'b01;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          // Only the owner's resp_ready can complete the response.
          if (|(resp_valid & resp_ready)) begin
            resp_valid <= 2'b00;
            prio       <= ~owner;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid <= 2'b00;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter: cycle-level reference model feeds a scoreboard queue,
// an independent monitor pops/compares responses. Honors ALU_ARB_OPCHECK_EN like the design.
module tb_alu_arbiter;

  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*DW-1:0] req_a;
  logic [2*DW-1:0] req_b;
  logic [7:0]      req_op;
  logic [1:0]      resp_valid;
  logic [1:0]      resp_ready;
  logic [DW-1:0]   resp_result;
  logic            resp_zero;
  logic            resp_err;
  logic            busy;
  logic [DW-1:0]   alu_data_rs1;
  logic [DW-1:0]   alu_source_2;
  logic [3:0]      alu_inst;
  logic [DW-1:0]   alu_result;
  logic            alu_zero;

  alu_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .busy(busy),
    .alu_data_rs1(alu_data_rs1), .alu_source_2(alu_source_2), .alu_inst(alu_inst),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            owner;
    logic [DW-1:0] result;
    bit            zero;
    bit            err;
    logic [3:0]    inst;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            due;
  } exp_t;

  exp_t sb[$];
  bit   owner_log[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  logic [DW-1:0] last_result;
  bit            last_zero;
  bit            last_err;

  function automatic logic [DW-1:0] alu_fn(input logic [3:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      default: return a ^ ~b;
    endcase
  endfunction

  function automatic bit op_ok(input logic [3:0] op);
`ifdef ALU_ARB_OPCHECK_EN
    return (op == 4'b0010) || (op == 4'b0110) || (op == 4'b0000) || (op == 4'b0001);
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Shared ALU stand-in: purely combinational on the arbiter's ALU port.
  always_comb begin
    alu_result = alu_fn(alu_inst, alu_data_rs1, alu_source_2);
    alu_zero   = (alu_result == '0);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: arbiter is either free, or owns one op accepted at m_acc that
  // becomes visible two cycles later and retires on the owner's resp_ready.
  bit         m_idle = 1'b1;
  bit         m_prio = 1'b0;
  bit         m_owner = 1'b0;
  int         m_acc = 0;
  logic [1:0] er;
  exp_t       ne;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flags", {resp_zero, resp_err}, 0);
      chk("rst_result", resp_result, 0);
      chk("rst_alu_port", {alu_inst, alu_data_rs1, alu_source_2}, 0);
      sb.delete();
      m_idle = 1'b1;
      m_prio = 1'b0;
    end else begin
      er = 2'b00;
      if (m_idle) begin
        if (req_valid == 2'b11) er = m_prio ? 2'b10 : 2'b01;
        else                    er = req_valid;
      end
      chk("req_ready", req_ready, er);
      chk("busy", busy, !m_idle);
      if (m_idle) begin
        chk("resp_valid_idle", resp_valid, 0);
        if (er != 2'b00) begin
          ne.owner = er[1];
          ne.a     = er[1] ? req_a[2*DW-1:DW] : req_a[DW-1:0];
          ne.b     = er[1] ? req_b[2*DW-1:DW] : req_b[DW-1:0];
          ne.inst  = er[1] ? req_op[7:4] : req_op[3:0];
          ne.err   = !op_ok(ne.inst);
          ne.result = ne.err ? '0 : alu_fn(ne.inst, ne.a, ne.b);
          ne.zero  = !ne.err && (ne.result == '0);
          if (ne.err) ne.inst = 4'b0010;
          ne.due   = cyc + 2;
          sb.push_back(ne);
          m_idle  = 1'b0;
          m_owner = er[1];
          m_acc   = cyc;
        end
      end else if (cyc >= m_acc + 2) begin
        chk("resp_valid", resp_valid, m_owner ? 2'b10 : 2'b01);
        if (resp_ready[m_owner]) begin
          m_prio = ~m_owner;
          m_idle = 1'b1;
        end
      end else begin
        chk("resp_valid_exec", resp_valid, 0);
      end
    end
  end

  // Monitor: compares every presented response against the scoreboard head.
  bit   prev_rv = 1'b0;
  exp_t me;

  always @(negedge clk) begin
    if (!rst && resp_valid != 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", resp_valid, 0);
      end else begin
        me = sb[0];
        if (!prev_rv) chk("latency", cyc, me.due);
        chk("resp_owner", resp_valid, me.owner ? 2'b10 : 2'b01);
        chk("resp_result", resp_result, me.result);
        chk("resp_zero", resp_zero, me.zero);
        chk("resp_err", resp_err, me.err);
        chk("alu_inst", alu_inst, me.inst);
        chk("alu_operands", {alu_data_rs1, alu_source_2}, {me.a, me.b});
        if (|(resp_valid & resp_ready)) begin
          void'(sb.pop_front());
          owner_log.push_back(me.owner);
          last_result = resp_result;
          last_zero   = resp_zero;
          last_err    = resp_err;
        end
      end
    end
    prev_rv = !rst && (resp_valid != 2'b00);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    req_valid  = 2'b00;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 2'b11;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit exp_log[$];
    rst = 1'b1;
    idle_inputs();
    tick(3);
    rst = 1'b0;

    // Single add on requester 0.
    req_valid = 2'b01;
    req_a = {32'd0, 32'd5};
    req_b = {32'd0, 32'd3};
    req_op = 8'h02;
    tick(1);
    idle_inputs();
    tick(5);
    chk("t_add_result", last_result, 32'd8);
    chk("t_add_zero", last_zero, 0);

    // Simultaneous requests right after reset: requester 0 first.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    owner_log.delete();
    req_a = {32'h0000_00F0, 32'd7};
    req_b = {32'h0000_000F, 32'd7};
    req_op = 8'h16;
    req_valid = 2'b11;
    tick(1);
    req_valid = 2'b10;
    tick(3);
    idle_inputs();
    tick(5);
    exp_log = '{1'b0, 1'b1};
    chk("t_tie_order_n", owner_log.size(), 2);
    if (owner_log.size() == 2) chk("t_tie_order", {owner_log[0], owner_log[1]}, {exp_log[0], exp_log[1]});
    chk("t_tie_last_result", last_result, 32'h0000_00FF);

    // Back-to-back contention alternates grants.
    owner_log.delete();
    req_valid = 2'b11;
    for (int i = 0; i < 12; i++) begin
      req_a  = {$urandom(), $urandom()};
      req_b  = {$urandom(), $urandom()};
      req_op = 8'h20;
      tick(1);
    end
    idle_inputs();
    tick(5);
    chk("t_alt_n", owner_log.size(), 4);
    if (owner_log.size() == 4)
      chk("t_alt_order", {owner_log[0], owner_log[1], owner_log[2], owner_log[3]}, 4'b0101);

    // Back-pressure: response held for 5 cycles.
    req_valid = 2'b01;
    req_a = {32'd0, 32'd100};
    req_b = {32'd0, 32'd23};
    req_op = 8'h02;
    resp_ready = 2'b00;
    tick(1);
    req_valid = 2'b11;
    tick(6);
    resp_ready = 2'b01;
    req_valid = 2'b00;
    tick(1);
    idle_inputs();
    tick(4);
    chk("t_hold_result", last_result, 32'd123);

    // Reset during EXEC aborts the op.
    req_valid = 2'b01;
    req_op = 8'h02;
    tick(1);
    idle_inputs();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(6);
    chk("t_abort_sb_empty", sb.size(), 0);

    // Opcode 1111 on requester 1.
    req_valid = 2'b10;
    req_a = {32'd2, 32'd0};
    req_b = {32'd2, 32'd0};
    req_op = 8'hF0;
    tick(1);
    idle_inputs();
    tick(5);
`ifdef ALU_ARB_OPCHECK_EN
    chk("t_badop_err", last_err, 1);
    chk("t_badop_result", last_result, 32'd0);
`else
    chk("t_badop_err", last_err, 0);
    chk("t_badop_result", last_result, 32'hFFFF_FFFF);
`endif

    // Random traffic with random back-pressure and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      req_valid = 2'($urandom_range(3));
      req_b = {$urandom(), $urandom()};
      req_a = ($urandom_range(3) == 0) ? req_b : {$urandom(), $urandom()};
      req_op = 8'($urandom());
      resp_ready = 2'($urandom_range(3));
      rst = ($urandom_range(199) == 0);
      tick(1);
    end
    rst = 1'b0;
    idle_inputs();
    tick(6);
    chk("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
